floo_no_rob_ctrl: RTL and testbench
===================================

# floo_no_rob_ctrl

Ordering controller for network interfaces configured with `NoRoB`. It sits on the AW or AR request path between the AXI manager port and the flit packer. It tracks outstanding transactions per AXI txnID and their destination, and it stalls any request whose txnID still has transactions outstanding to a different destination. Responses therefore come back in order without a reorder buffer. One instance is used per channel: AW with B retirement, or AR with R-last retirement.

## Interface

Parameters:
- `NumIds`, default 4: number of tracked txnIDs. `IdWidth = $clog2(NumIds)`, with a minimum of 1.
- `MaxTxnsPerId`, default 8: maximum outstanding transactions per txnID. Counter width is `$clog2(MaxTxnsPerId+1)`.
- `DestWidth`, default 8: width of the destination ID (XY coordinate or endpoint ID).

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: **one clock; reset is synchronous and active-high**.
- `req_valid_i`, input, 1: upstream request valid.
- `req_ready_o`, output, 1: upstream request ready.
- `req_id_i`, input, IdWidth: txnID of the request.
- `req_dest_i`, input, DestWidth: destination ID of the request.
- `req_valid_o`, output, 1: request valid towards the packer.
- `req_ready_i`, input, 1: packer ready.
- `rsp_pop_i`, input, 1: one transaction retires this cycle (B handshake, or R handshake with last).
- `rsp_id_i`, input, IdWidth: txnID of the retiring transaction.
- `idle_o`, output, 1: no transaction is outstanding on any ID.
- `err_o`, output, 1: sticky underflow flag (see Configuration).

## Operation

- Per-ID state: counter `cnt[i]` and register `dest[i]`. Each ID behaves as an implicit state machine:
  - IDLE: `cnt==0`.
  - ACTIVE: `0<cnt<Max`.
  - FULL: `cnt==Max`.
- A request is allowed when either:
  - `cnt[id]==0`, or
  - `dest[id]==req_dest_i` and `cnt[id]<MaxTxnsPerId`.
- `req_valid_o = req_valid_i & allowed`.
- `req_ready_o = req_ready_i & allowed`.
- The payload is not touched by this block. It travels alongside on the external path.
- Push is the handshake `req_valid_o & req_ready_i`. On push: `cnt[id]++` and `dest[id] <= req_dest_i`.
- Pop (`rsp_pop_i`): `cnt[rsp_id_i]--`.
- Push and pop on the same ID in the same cycle: count is unchanged and `dest` is written with the same value.
- Push and pop on different IDs: both updates apply independently.
- Pop while `cnt==0`:
  - The decrement is suppressed; the counter never wraps.
  - A simultaneous push to that ID still increments the counter, to 1.
  - `err_o` behaviour is given under Configuration.
- A push while FULL cannot happen, because `allowed` is 0 in that state.
- `dest[i]` keeps its stale value in IDLE. It is ignored there because `cnt==0` allows any destination.
- `idle_o` is 1 exactly when every `cnt[i]` is 0.

## Timing

- Reset values:
  - all `cnt` = 0, all `dest` = 0.
  - `err_o` = 0.
  - `idle_o` = 1.
  - `req_valid_o` and `req_ready_o` follow the combinational formula with the reset state, so they equal `req_valid_i` / `req_ready_i` in the cycle after reset.
- Request path: zero latency, purely combinational from registered state plus the inputs. There is no combinational path from `rsp_pop_i` to the request outputs.
- State update: a push or pop in cycle t is visible in cycle t+1.
- A pop that frees an ID in cycle t allows a different destination on that ID from cycle t+1. There is no same-cycle bypass.
- Reset asserted mid-operation clears all state on the next edge. Outstanding responses that arrive afterwards are pops at `cnt==0`.
- `idle_o` is registered-derived and asserts one cycle after the final pop.

## Configuration

- Macro: `FLOO_NO_ROB_ERR_EN`.
- Defined:
  - `err_o` is set on any pop with `cnt[rsp_id_i]==0`.
  - It stays set until `rst_i`.
- Undefined:
  - `err_o` is tied to 0 and the detection logic is removed.
  - Underflow suppression remains in both builds.

## Test plan

1. Reset, then 3 pushes with ID 1 and dest 0x05, with `req_ready_i`=1 → all three pass. `cnt[1]`=3 and `idle_o`=0.
2. With `cnt[1]`=2 at dest 0x05, request ID 1 with dest 0x07 → `req_valid_o`=0 and `req_ready_o`=0. Pop ID 1 twice; the request passes in the cycle after the second pop.
3. Push ID 2 with `MaxTxnsPerId`=8 until full → the 9th request is stalled. One pop re-enables it the following cycle.
4. Simultaneous push and pop on ID 0 with `cnt`=4 → `cnt` stays 4. Simultaneous push on ID 0 and pop on ID 3 → each counter updates independently.
5. Pop ID 3 at `cnt`=0:
   - With the macro defined: `err_o`=1 next cycle and sticky, `cnt` stays 0.
   - With the macro undefined: `err_o` stays 0.
6. Reset asserted with 5 transactions outstanding → next cycle all counters are 0, `idle_o`=1, and a request to any destination passes.

Source files
------------

// File: rtl/floo_no_rob_ctrl.sv
// floo_no_rob_ctrl
// Ordering controller for NoRoB network interfaces. It sits on one AXI request
// channel (AW or AR) and stalls a request whose txnID still has transactions
// outstanding to a different destination. Responses therefore return in order
// without a reorder buffer.
//
// Optional feature: define FLOO_NO_ROB_ERR_EN to get a sticky err_o that flags
// a retirement on an ID with nothing outstanding. Without the macro, err_o is
// tied low. Underflow suppression is present in both builds.
//
// Handshake: the upstream side completes a transfer when req_valid_i and
// req_ready_o are both high. The downstream side completes a transfer when
// req_valid_o and req_ready_i are both high. These are the same event, because
// both outputs are gated by the same 'allowed' term. The payload travels beside
// this block and is never touched here. Valid never depends on ready. Ready
// never depends on valid.
module floo_no_rob_ctrl #(
  parameter int unsigned NumIds       = 4,
  parameter int unsigned MaxTxnsPerId = 8,
  parameter int unsigned DestWidth    = 8,
  localparam int unsigned IdWidth     = (NumIds > 1) ? $clog2(NumIds) : 1,
  localparam int unsigned CntWidth    = $clog2(MaxTxnsPerId + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IdWidth-1:0]   req_id_i,
  input  logic [DestWidth-1:0] req_dest_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  input  logic                 rsp_pop_i,
  input  logic [IdWidth-1:0]   rsp_id_i,
  output logic                 idle_o,
  output logic                 err_o
);

  // Each ID is an implicit state machine, decoded from its counter. It is
  // exposed as id_state so that checkers can bind to it.
  typedef enum logic [1:0] {
    ID_IDLE   = 2'd0,
    ID_ACTIVE = 2'd1,
    ID_FULL   = 2'd2
  } id_state_e;

  logic [CntWidth-1:0]  cnt_q  [NumIds];
  logic [DestWidth-1:0] dest_q [NumIds];
  id_state_e            id_state [NumIds];

  logic [NumIds-1:0]    zero_vec;
  logic [NumIds-1:0]    push_hit;
  logic [NumIds-1:0]    pop_hit;
  id_state_e            sel_state;
  logic [DestWidth-1:0] sel_dest;
  logic                 allowed;
  logic                 push;

  // Decode the per-ID state and the per-ID push/pop strobes from registered counters and the inputs.
  always_comb begin
    zero_vec = '0;
    push_hit = '0;
    pop_hit  = '0;
    for (int i = 0; i < NumIds; i++) begin
      id_state[i] = ID_ACTIVE;
      if (cnt_q[i] == '0) begin
        id_state[i] = ID_IDLE;
      end else if (cnt_q[i] == CntWidth'(MaxTxnsPerId)) begin
        id_state[i] = ID_FULL;
      end
      zero_vec[i] = (cnt_q[i] == '0);
      push_hit[i] = push && (req_id_i == IdWidth'(i));
      pop_hit[i]  = rsp_pop_i && (rsp_id_i == IdWidth'(i));
    end
  end

  // Select the state and destination of the requested ID. This only looks at registered state, never at rsp_pop_i.
  always_comb begin
    sel_state = ID_IDLE;
    sel_dest  = '0;
    for (int i = 0; i < NumIds; i++) begin
      if (req_id_i == IdWidth'(i)) begin
        sel_state = id_state[i];
        sel_dest  = dest_q[i];
      end
    end
  end

  // An idle ID accepts any destination. A busy ID accepts only its current destination, and only while it has room.
  assign allowed     = (sel_state == ID_IDLE) ||
                       ((sel_dest == req_dest_i) && (sel_state != ID_FULL));
  assign req_valid_o = req_valid_i & allowed;
  assign req_ready_o = req_ready_i & allowed;
  assign push        = req_valid_o & req_ready_i;
  assign idle_o      = &zero_vec;

  // Per-ID counter and destination update. A pop on an empty ID is ignored, so the counter never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++) begin
        cnt_q[i]  <= '0;
        dest_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        if (push_hit[i] && !pop_hit[i]) begin
          cnt_q[i] <= cnt_q[i] + CntWidth'(1);
        end else if (!push_hit[i] && pop_hit[i] && !zero_vec[i]) begin
          cnt_q[i] <= cnt_q[i] - CntWidth'(1);
        end else if (push_hit[i] && pop_hit[i] && zero_vec[i]) begin
          // The pop is an underflow and is dropped, but the push still counts.
          cnt_q[i] <= CntWidth'(1);
        end
        if (push_hit[i]) begin
          dest_q[i] <= req_dest_i;
        end
      end
    end
  end

`ifdef FLOO_NO_ROB_ERR_EN
  logic err_q;

  // Sticky underflow flag. It is set by any pop on an empty ID and is cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (|(pop_hit & zero_vec)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_floo_no_rob_ctrl.sv
// Testbench for floo_no_rob_ctrl using the default parameters (4 IDs, 8 per ID, 8-bit dest).
// A negedge monitor pops every downstream handshake from the expected queue.
module tb_floo_no_rob_ctrl;

  localparam int ID_W   = 2;
  localparam int DEST_W = 8;
  localparam int W      = ID_W + DEST_W;
`ifdef FLOO_NO_ROB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic              req_valid_i, req_ready_o, req_valid_o, req_ready_i;
  logic [ID_W-1:0]   req_id_i, rsp_id_i;
  logic [DEST_W-1:0] req_dest_i;
  logic              rsp_pop_i, idle_o, err_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  floo_no_rob_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_id_i(req_id_i), .req_dest_i(req_dest_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .rsp_pop_i(rsp_pop_i), .rsp_id_i(rsp_id_i),
    .idle_o(idle_o), .err_o(err_o)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // Monitor: every downstream handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst_i && req_valid_o && req_ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL handshake: got id=%0d dest=%h, required none", req_id_i, req_dest_i);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({req_id_i, req_dest_i} !== e) begin
          bad++;
          $display("FAIL handshake: got %h, required %h", {req_id_i, req_dest_i}, e);
        end
      end
    end
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic v, input logic r, input logic [ID_W-1:0] id, input logic [DEST_W-1:0] d);
    req_valid_i = v; req_ready_i = r; req_id_i = id; req_dest_i = d;
  endtask

  task automatic set_pop(input logic p, input logic [ID_W-1:0] id);
    rsp_pop_i = p; rsp_id_i = id;
  endtask

  // Drive n accepted pushes of (id, dest); each must be allowed.
  task automatic push_n(input int n, input logic [ID_W-1:0] id, input logic [DEST_W-1:0] d);
    set_req(1'b1, 1'b1, id, d);
    for (int k = 0; k < n; k++) begin
      #1;
      total++;
      if (req_valid_o !== 1'b1) begin bad++; $display("FAIL push_allowed id=%0d k=%0d: valid_o=%b required 1", id, k, req_valid_o); end
      exp_q.push_back({id, d});
      tick();
    end
    set_req(1'b0, 1'b1, '0, '0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; set_req(1'b0, 1'b0, '0, '0); set_pop(1'b0, '0);
    tick(); tick();
    rst_i = 1'b0; set_req(1'b0, 1'b1, 2'd2, 8'h33);
    #1;
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b required 1", idle_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", err_o); end
    total++; if ({req_valid_o, req_ready_o} !== 2'b01) begin bad++; $display("FAIL reset_passthru_a: got %b required 01", {req_valid_o, req_ready_o}); end
    set_req(1'b1, 1'b0, 2'd2, 8'h33);
    #1;
    total++; if ({req_valid_o, req_ready_o} !== 2'b10) begin bad++; $display("FAIL reset_passthru_b: got %b required 10", {req_valid_o, req_ready_o}); end
    set_req(1'b0, 1'b1, '0, '0);
    tick();
  endtask

  task automatic test_push_basic();
    push_n(3, 2'd1, 8'h05);
    #1;
    total++; if (idle_o !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b required 0", idle_o); end
  endtask

  task automatic test_dest_stall();
    // Bring ID 1 from 3 outstanding down to 2.
    set_pop(1'b1, 2'd1); tick(); set_pop(1'b0, '0);
    set_req(1'b1, 1'b1, 2'd1, 8'h07);
    #1;
    total++; if ({req_valid_o, req_ready_o} !== 2'b00) begin bad++; $display("FAIL stall_dest: got %b required 00", {req_valid_o, req_ready_o}); end
    set_pop(1'b1, 2'd1);
    #1;
    total++; if (req_valid_o !== 1'b0) begin bad++; $display("FAIL stall_pop1: got %b required 0", req_valid_o); end
    tick();
    #1;
    total++; if (req_valid_o !== 1'b0) begin bad++; $display("FAIL stall_pop2_no_bypass: got %b required 0", req_valid_o); end
    tick();
    set_pop(1'b0, '0);
    #1;
    total++; if ({req_valid_o, req_ready_o} !== 2'b11) begin bad++; $display("FAIL stall_release: got %b required 11", {req_valid_o, req_ready_o}); end
    exp_q.push_back({2'd1, 8'h07});
    tick();
    set_req(1'b0, 1'b1, '0, '0);
    set_pop(1'b1, 2'd1); tick(); set_pop(1'b0, '0);
    #1;
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL stall_drained_idle: got %b required 1", idle_o); end
  endtask

  task automatic test_full();
    push_n(8, 2'd2, 8'h0A);
    set_req(1'b1, 1'b1, 2'd2, 8'h0A);
    #1;
    total++; if ({req_valid_o, req_ready_o} !== 2'b00) begin bad++; $display("FAIL full_stall: got %b required 00", {req_valid_o, req_ready_o}); end
    set_pop(1'b1, 2'd2);
    #1;
    total++; if (req_valid_o !== 1'b0) begin bad++; $display("FAIL full_no_bypass: got %b required 0", req_valid_o); end
    tick();
    set_pop(1'b0, '0);
    #1;
    total++; if (req_valid_o !== 1'b1) begin bad++; $display("FAIL full_reenable: got %b required 1", req_valid_o); end
    exp_q.push_back({2'd2, 8'h0A});
    tick();
    set_req(1'b0, 1'b1, '0, '0);
    for (int k = 0; k < 8; k++) begin set_pop(1'b1, 2'd2); tick(); end
    set_pop(1'b0, '0);
    #1;
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL full_drained_idle: got %b required 1", idle_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL full_err: got %b required 0", err_o); end
  endtask

  task automatic test_simul();
    push_n(1, 2'd3, 8'h22);
    push_n(4, 2'd0, 8'h11);
    // Push and pop on ID 0 together: the count stays at 4.
    set_req(1'b1, 1'b1, 2'd0, 8'h11); set_pop(1'b1, 2'd0);
    #1;
    total++; if (req_valid_o !== 1'b1) begin bad++; $display("FAIL simul_same_allowed: got %b required 1", req_valid_o); end
    exp_q.push_back({2'd0, 8'h11});
    tick();
    // Push on ID 0 and pop on ID 3 together: ID 0 goes to 5 and ID 3 goes to 0.
    set_pop(1'b1, 2'd3);
    #1;
    exp_q.push_back({2'd0, 8'h11});
    tick();
    set_pop(1'b0, '0);
    set_req(1'b1, 1'b0, 2'd3, 8'h44);
    #1;
    total++; if (req_valid_o !== 1'b1) begin bad++; $display("FAIL simul_id3_freed: got %b required 1", req_valid_o); end
    set_req(1'b0, 1'b1, '0, '0);
    for (int k = 0; k < 4; k++) begin set_pop(1'b1, 2'd0); tick(); end
    set_pop(1'b0, '0);
    #1;
    total++; if (idle_o !== 1'b0) begin bad++; $display("FAIL simul_cnt0_after4: idle=%b required 0", idle_o); end
    set_pop(1'b1, 2'd0); tick(); set_pop(1'b0, '0);
    #1;
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL simul_cnt0_after5: idle=%b required 1", idle_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL simul_err: got %b required 0", err_o); end
  endtask

  task automatic test_underflow();
    set_pop(1'b1, 2'd3); tick(); set_pop(1'b0, '0);
    #1;
    total++; if (err_o !== ERR_EXP) begin bad++; $display("FAIL uflow_err: got %b required %b", err_o, ERR_EXP); end
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL uflow_idle: got %b required 1", idle_o); end
    tick(); tick();
    total++; if (err_o !== ERR_EXP) begin bad++; $display("FAIL uflow_sticky: got %b required %b", err_o, ERR_EXP); end
    // The counter must have stayed at 0: one push and one pop leave the ID idle again.
    push_n(1, 2'd3, 8'h55);
    #1;
    total++; if (idle_o !== 1'b0) begin bad++; $display("FAIL uflow_one_out: idle=%b required 0", idle_o); end
    set_pop(1'b1, 2'd3); tick(); set_pop(1'b0, '0);
    #1;
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL uflow_no_wrap: idle=%b required 1", idle_o); end
  endtask

  task automatic test_reset_mid();
    push_n(3, 2'd0, 8'h01);
    push_n(2, 2'd1, 8'h02);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    #1;
    total++; if (idle_o !== 1'b1) begin bad++; $display("FAIL rstmid_idle: got %b required 1", idle_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rstmid_err: got %b required 0", err_o); end
    push_n(1, 2'd0, 8'h99);
    #1;
    total++; if (idle_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b required 0", idle_o); end
  endtask

  // Run the scenarios in sequence, then check that the queue is empty and print the summary.
  initial begin
    test_reset();
    test_push_basic();
    test_dest_stall();
    test_full();
    test_simul();
    test_underflow();
    test_reset_mid();
    tick(); tick();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL queue_drained: %0d entries left, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
